// File: rtl/regfile_access_if.sv
// Handshake bundle between an operand consumer / writeback producer and
// regfile_access_ctrl.
//   req_*  : operand-fetch request (valid/ready, three source indices)
//   op_*   : returned operands (valid/ready, three data words)
//   wb_*   : writeback request (valid/ready, destination index and data)
// Modports:
//   slave  - the controller side (regfile_access_ctrl)
//   master - the requester side (pipeline or testbench)
interface regfile_access_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 4
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_src1;
    logic [AW-1:0] req_src2;
    logic [AW-1:0] req_src3;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] op_c;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_dst;
    logic [DW-1:0] wb_data;

    modport slave (
        input  req_valid, req_src1, req_src2, req_src3, op_ready,
        input  wb_valid, wb_dst, wb_data,
        output req_ready, op_valid, op_a, op_b, op_c, wb_ready
    );

    modport master (
        output req_valid, req_src1, req_src2, req_src3, op_ready,
        output wb_valid, wb_dst, wb_data,
        input  req_ready, op_valid, op_a, op_b, op_c, wb_ready
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Initiator-side controller for a three-read/one-write register file.
// Fetches three operands per request over a valid/ready handshake, queues
// writebacks in a small FIFO and drains them one per cycle into the write
// port. Requests whose sources match any queued writeback are held off, so
// returned operands reflect every writeback accepted before the request.
//
// Ports:
//   clk, rst        clock (posedge) and synchronous active-high reset
//   bus             regfile_access_if.slave: req_*, op_*, wb_* handshakes
//   regread         register file read enable (high only in S_READ)
//   readregsrc1..3  register file read indices (latched request sources)
//   regwrite        register file write enable (FIFO head valid, not S_READ)
//   regwritedst     register file write index (FIFO head)
//   writedata       register file write data (FIFO head)
//   a, b, c         register file read data
//   stall_cnt       hazard stall counter
//
// Optional feature: define REGFILE_ACCESS_STATS_EN to count cycles in which an
// idle controller sees a valid request blocked by a hazard (saturating).
// Without it stall_cnt is tied to zero.
module regfile_access_ctrl #(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned WB_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_access_if.slave      bus,
    output logic                 regread,
    output logic [AW-1:0]        readregsrc1,
    output logic [AW-1:0]        readregsrc2,
    output logic [AW-1:0]        readregsrc3,
    output logic                 regwrite,
    output logic [AW-1:0]        regwritedst,
    output logic [DW-1:0]        writedata,
    input  logic [DW-1:0]        a,
    input  logic [DW-1:0]        b,
    input  logic [DW-1:0]        c,
    output logic [15:0]          stall_cnt
);

    localparam int unsigned PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] src1_q, src2_q, src3_q;
    logic [DW-1:0] op_a_q, op_b_q, op_c_q;

    logic [AW-1:0] fifo_dst_q  [WB_DEPTH];
    logic [DW-1:0] fifo_data_q [WB_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   count_q;

    logic full, empty, push, pop, hazard, accept, req_ready;
    logic [PW-1:0] off;

    assign full  = (count_q == (PW+1)'(WB_DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.wb_valid && !full;
    // Drain is paused in S_READ so a read never sees a same-cycle write.
    assign pop   = !empty && (state_q != S_READ);

    // Hazard scan over the FIFO as it stands at the start of the cycle; the
    // head being drained this cycle still counts.
    always_comb begin
        hazard = 1'b0;
        off    = '0;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) &&
                ((fifo_dst_q[i] == bus.req_src1) ||
                 (fifo_dst_q[i] == bus.req_src2) ||
                 (fifo_dst_q[i] == bus.req_src3))) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = (state_q == S_IDLE) && !hazard;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready) begin
                    accept  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ:  state_d = S_HOLD;
            S_HOLD:  if (bus.op_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            src1_q   <= '0;
            src2_q   <= '0;
            src3_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_c_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                src1_q <= bus.req_src1;
                src2_q <= bus.req_src2;
                src3_q <= bus.req_src3;
            end
            if (state_q == S_READ) begin
                op_a_q <= a;
                op_b_q <= b;
                op_c_q <= c;
            end
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dst_q[wr_ptr_q]  <= bus.wb_dst;
            fifo_data_q[wr_ptr_q] <= bus.wb_data;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.op_valid  = (state_q == S_HOLD);
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.op_c      = op_c_q;
    assign bus.wb_ready  = !full;

    assign regread     = (state_q == S_READ);
    assign readregsrc1 = src1_q;
    assign readregsrc2 = src2_q;
    assign readregsrc3 = src3_q;
    assign regwrite    = pop;
    assign regwritedst = fifo_dst_q[rd_ptr_q];
    assign writedata   = fifo_data_q[rd_ptr_q];

`ifdef REGFILE_ACCESS_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((state_q == S_IDLE) && bus.req_valid && hazard &&
                     (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_regfile_access_ctrl.sv
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        regread, regwrite;
    logic [3:0]  readregsrc1, readregsrc2, readregsrc3, regwritedst;
    logic [15:0] writedata, a, b, c, stall_cnt;
    logic [15:0] rf [16];

    int checks = 0;
    int errors = 0;

    regfile_access_if #(.DW(16), .AW(4)) bus ();

    regfile_access_ctrl #(.DW(16), .AW(4), .WB_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .regread     (regread),
        .readregsrc1 (readregsrc1),
        .readregsrc2 (readregsrc2),
        .readregsrc3 (readregsrc3),
        .regwrite    (regwrite),
        .regwritedst (regwritedst),
        .writedata   (writedata),
        .a           (a),
        .b           (b),
        .c           (c),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // Register file model: asynchronous read, write on negedge.
    bit loaded = 1'b0;
    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'(i * 16'h0011);
            rf[7]  <= 16'h0777;
            loaded = 1'b1;
        end else if (regwrite) begin
            rf[regwritedst] <= writedata;
        end
    end

    assign a = rf[readregsrc1];
    assign b = rf[readregsrc2];
    assign c = rf[readregsrc3];

    typedef struct {
        logic [3:0]  s1, s2, s3;
        logic [15:0] ea, eb, ec;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3,
                          input logic [15:0] ea, input logic [15:0] eb,
                          input logic [15:0] ec);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_src1  = s1;
        bus.req_src2  = s2;
        bus.req_src3  = s3;
        #1;
        while (!bus.req_ready && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
        step();
        bus.req_valid = 1'b0;
        #1;
        chk("read_regread", {31'd0, regread}, 32'd1);
        chk("read_src1", {28'd0, readregsrc1}, {28'd0, s1});
        chk("read_src2", {28'd0, readregsrc2}, {28'd0, s2});
        chk("read_src3", {28'd0, readregsrc3}, {28'd0, s3});
        chk("read_op_valid", {31'd0, bus.op_valid}, 32'd0);
        step();
        chk("hold_op_valid", {31'd0, bus.op_valid}, 32'd1);
        chk("hold_regread", {31'd0, regread}, 32'd0);
        chk("op_a", {16'd0, bus.op_a}, {16'd0, ea});
        chk("op_b", {16'd0, bus.op_b}, {16'd0, eb});
        chk("op_c", {16'd0, bus.op_c}, {16'd0, ec});
        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;
        #1;
        chk("op_valid_drop", {31'd0, bus.op_valid}, 32'd0);
    endtask

    initial begin
        int k;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_src1  = '0;
        bus.req_src2  = '0;
        bus.req_src3  = '0;
        bus.op_ready  = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_dst    = '0;
        bus.wb_data   = '0;

        vecs[0] = '{s1: 4'd1, s2: 4'd2,  s3: 4'd3,  ea: 16'h0011, eb: 16'h0022, ec: 16'h0033};
        vecs[1] = '{s1: 4'd3, s2: 4'd2,  s3: 4'd1,  ea: 16'h0033, eb: 16'h0022, ec: 16'h0011};
        vecs[2] = '{s1: 4'd0, s2: 4'd15, s3: 4'd7,  ea: 16'h0000, eb: 16'h00FF, ec: 16'h0777};
        vecs[3] = '{s1: 4'd4, s2: 4'd4,  s3: 4'd10, ea: 16'h0044, eb: 16'h0044, ec: 16'h00AA};

        repeat (3) step();
        rst = 1'b0;
        #1;
        // Reset state
        chk("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
        chk("rst_op_a", {16'd0, bus.op_a}, 32'd0);
        chk("rst_op_b", {16'd0, bus.op_b}, 32'd0);
        chk("rst_op_c", {16'd0, bus.op_c}, 32'd0);
        chk("rst_regread", {31'd0, regread}, 32'd0);
        chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
        chk("rst_src1", {28'd0, readregsrc1}, 32'd0);
        chk("rst_wb_ready", {31'd0, bus.wb_ready}, 32'd1);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // Plain operand fetches
        for (int i = 0; i < 4; i++) begin
            do_req(vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].ea, vecs[i].eb, vecs[i].ec);
        end

        // Queued writeback blocks a matching request until drained
        bus.wb_valid = 1'b1;
        bus.wb_dst   = 4'd5;
        bus.wb_data  = 16'hBEEF;
        step();
        bus.wb_valid  = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_src1  = 4'd5;
        bus.req_src2  = 4'd0;
        bus.req_src3  = 4'd0;
        #1;
        chk("haz_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("haz_regwrite", {31'd0, regwrite}, 32'd1);
        chk("haz_wdst", {28'd0, regwritedst}, 32'd5);
        step();
        chk("haz_clear", {31'd0, bus.req_ready}, 32'd1);
        do_req(4'd5, 4'd0, 4'd0, 16'hBEEF, 16'h0000, 16'h0000);

        // Writeback pushed in the accept cycle is younger than the request
        bus.wb_valid  = 1'b1;
        bus.wb_dst    = 4'd7;
        bus.wb_data   = 16'h1234;
        bus.req_valid = 1'b1;
        bus.req_src1  = 4'd7;
        bus.req_src2  = 4'd7;
        bus.req_src3  = 4'd7;
        #1;
        chk("young_req_ready", {31'd0, bus.req_ready}, 32'd1);
        step();
        bus.wb_valid  = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("young_read_nowrite", {31'd0, regwrite}, 32'd0);
        chk("young_regread", {31'd0, regread}, 32'd1);
        step();
        chk("young_write", {31'd0, regwrite}, 32'd1);
        chk("young_wdst", {28'd0, regwritedst}, 32'd7);
        chk("young_wdata", {16'd0, writedata}, 32'h1234);
        chk("young_op_a", {16'd0, bus.op_a}, 32'h0777);
        chk("young_op_b", {16'd0, bus.op_b}, 32'h0777);
        chk("young_op_c", {16'd0, bus.op_c}, 32'h0777);
        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;
        do_req(4'd7, 4'd1, 4'd7, 16'h1234, 16'h0011, 16'h1234);

        // Operands hold while op_ready=0, then reset mid-operation
        bus.req_valid = 1'b1;
        bus.req_src1  = 4'd1;
        bus.req_src2  = 4'd2;
        bus.req_src3  = 4'd3;
        step();
        bus.req_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.wb_valid = 1'b1;
            bus.wb_dst   = 4'd12;
            bus.wb_data  = 16'hC000 + 16'(i);
            #1;
            chk("stable_valid", {31'd0, bus.op_valid}, 32'd1);
            chk("stable_op_a", {16'd0, bus.op_a}, 32'h0011);
            chk("stable_op_b", {16'd0, bus.op_b}, 32'h0022);
            chk("stable_op_c", {16'd0, bus.op_c}, 32'h0033);
            if (i > 0) chk("hold_drain", {31'd0, regwrite}, 32'd1);
            step();
        end
        rst = 1'b1;
        step();
        rst          = 1'b0;
        bus.wb_valid = 1'b0;
        #1;
        chk("mid_rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
        chk("mid_rst_fifo_empty", {31'd0, regwrite}, 32'd0);
        chk("mid_rst_op_a", {16'd0, bus.op_a}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Hazard stall for three cycles
        bus.wb_valid = 1'b1;
        bus.wb_dst   = 4'd6;
        bus.wb_data  = 16'h6001;
        step();
        bus.req_valid = 1'b1;
        bus.req_src1  = 4'd6;
        bus.req_src2  = 4'd0;
        bus.req_src3  = 4'd0;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) bus.wb_data = 16'h6002 + 16'(i);
            else bus.wb_valid = 1'b0;
            #1;
            chk("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
            step();
        end
        chk("stall_release", {31'd0, bus.req_ready}, 32'd1);
`ifdef REGFILE_ACCESS_STATS_EN
        chk("stall_cnt", {16'd0, stall_cnt}, 32'd3);
`else
        chk("stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
        do_req(4'd6, 4'd0, 4'd0, 16'h6003, 16'h0000, 16'h0000);

        // FIFO fills only through S_READ cycles; check full, refusal, drain order
        k = 0;
        for (int cy = 0; cy < 14; cy++) begin
            bus.req_valid = (cy == 0 || cy == 3 || cy == 6);
            bus.req_src1  = 4'd1;
            bus.req_src2  = 4'd2;
            bus.req_src3  = 4'd3;
            bus.op_ready  = (cy == 2 || cy == 5 || cy == 12);
            bus.wb_valid  = (cy <= 8);
            bus.wb_dst    = 4'd8 + 4'(cy % 4);
            bus.wb_data   = 16'hA000 + 16'(cy);
            #1;
            if (cy == 0 || cy == 3 || cy == 6)
                chk("fill_req_ready", {31'd0, bus.req_ready}, 32'd1);
            if (cy == 1 || cy == 4 || cy == 7) begin
                chk("fill_read_nowrite", {31'd0, regwrite}, 32'd0);
                chk("fill_regread", {31'd0, regread}, 32'd1);
            end
            if (cy == 7) chk("fill_wb_ready_3", {31'd0, bus.wb_ready}, 32'd1);
            if (cy == 8) chk("fill_wb_ready_full", {31'd0, bus.wb_ready}, 32'd0);
            if (cy == 12) chk("fill_drained", {31'd0, regwrite}, 32'd0);
            if (regwrite) begin
                chk("drain_wdata", {16'd0, writedata}, {16'd0, 16'hA000 + 16'(k)});
                chk("drain_wdst", {28'd0, regwritedst}, {28'd0, 4'd8 + 4'(k % 4)});
                k++;
            end
            step();
        end
        bus.op_ready = 1'b0;
        bus.wb_valid = 1'b0;
        chk("drain_count", k, 8);
        chk("drain_rf8", {16'd0, rf[8]}, 32'hA004);
        chk("drain_rf11", {16'd0, rf[11]}, 32'hA007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
